// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF_RD = 2'd1,
        OWN_D_RD  = 2'd2
    } owner_t;

    localparam logic [3:0] BE_FULL              = 4'hF;
    localparam int         STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, load/store port and memory port of the unified memory arbiter.
// The slave modport is the arbiter side; master is the requester/memory side.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants taken while fetch is waiting; force_if
// flags that fetch must win the next conflict.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic force_if
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign force_if = (starve_cnt == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported memory arbiter: data wins conflicts, fetch is forced after
// STARVE_LIMIT data grants. Optional perf counters under MEM_ARB_PERF_EN.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int CNT_W        = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    unified_mem_arbiter_if.slave   bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]            perf_if_gnt,
    output logic [31:0]            perf_d_gnt,
    output logic [31:0]            perf_conflict
`endif
);

    logic   force_if;
    logic   if_gnt_c;
    logic   d_gnt_c;
    owner_t owner_q;
    owner_t owner_nxt;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .if_gnt   (if_gnt_c),
        .d_gnt    (d_gnt_c),
        .force_if (force_if)
    );

    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if (!rst) begin
            if (bus.if_req && bus.d_req) begin
                if (force_if) if_gnt_c = 1'b1;
                else          d_gnt_c  = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_c = 1'b1;
            end else if (bus.d_req) begin
                d_gnt_c = 1'b1;
            end
        end
    end

    // Owner of the access whose read data returns on the next cycle.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (if_gnt_c)                   owner_nxt = OWN_IF_RD;
        else if (d_gnt_c && !bus.d_we)  owner_nxt = OWN_D_RD;
    end

    always_ff @(posedge clk) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_nxt;
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_en    = if_gnt_c | d_gnt_c;
    assign bus.mem_we    = d_gnt_c & bus.d_we;
    assign bus.mem_addr  = if_gnt_c ? bus.if_addr[ADDR_W+1:2] : bus.d_addr[ADDR_W+1:2];
    assign bus.mem_be    = if_gnt_c ? BE_FULL : bus.d_be;
    assign bus.mem_wdata = bus.d_wdata;

    // Gating with rst drops a return that was in flight when reset hit.
    assign bus.if_rvalid = (owner_q == OWN_IF_RD) && !rst;
    assign bus.d_rvalid  = (owner_q == OWN_D_RD)  && !rst;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_W+2],  bus.d_addr[1:0]};

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_gnt   <= '0;
            perf_d_gnt    <= '0;
            perf_conflict <= '0;
        end else begin
            if (if_gnt_c)                 perf_if_gnt   <= perf_if_gnt + 32'd1;
            if (d_gnt_c)                  perf_d_gnt    <= perf_d_gnt + 32'd1;
            if (bus.if_req && bus.d_req)  perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates a single-ported unified instruction/data memory between the instruction-fetch port and the load/store port, all on one clock. It issues at most one memory access per cycle. Read data returns one cycle after the grant and is steered to the port that owns the access. Data accesses win conflicts, and a starvation counter guarantees fetch forward progress.

Parameters:
ADDR_W, 12, memory word-address width (byte address bits [ADDR_W+1:2] used)
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced
CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch requests a read this cycle
if_addr  in  32  fetch byte address
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
if_rdata  out  32  fetch read data
d_req  in  1  data port requests access
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_be  in  4  store byte enables
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  d_rdata valid (cycle after a load grant)
d_rdata  out  32  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables
mem_rdata  in  32  memory read data, valid one cycle after mem_en & !mem_we

Behaviour:
- Reset (rst=1 at a clk edge): owner register = NONE, starve_cnt = 0, if_rvalid = 0, d_rvalid = 0. if_gnt/d_gnt/mem_en are combinational and are forced 0 while rst=1.
- Grant decision each cycle, combinational:
  - Only if_req: if_gnt = 1.
  - Only d_req: d_gnt = 1.
  - Both: d_gnt = 1, unless starve_cnt == STARVE_LIMIT, in which case if_gnt = 1.
  - Never both grants in the same cycle.
- Memory drive on a grant:
  - mem_en = 1 and mem_addr = granted addr[ADDR_W+1:2].
  - Fetch grant: mem_we = 0, mem_be = 4'hF.
  - Data grant: mem_we = d_we, mem_be = d_be, mem_wdata = d_wdata.
  - With no grant, mem_en = 0 and mem_we = 0.
- Owner register (states NONE / IF_RD / D_RD), updated every edge:
  - IF_RD on a fetch grant.
  - D_RD on a data load grant.
  - NONE on a store grant or no grant.
- Read return:
  - if_rvalid = (owner == IF_RD); d_rvalid = (owner == D_RD).
  - Both rdata outputs carry mem_rdata and are qualified only by their own rvalid.
- Latency and throughput: grant to rvalid is exactly 1 cycle. Back-to-back grants are allowed, giving 1 access per cycle.
- Starvation counter starve_cnt:
  - +1 on a data grant while if_req = 1, saturating at STARVE_LIMIT.
  - Cleared on a fetch grant or whenever if_req = 0.
- Requesters hold req, addr and data stable until their gnt is seen.
- Reset asserted while a read is outstanding: that rvalid is suppressed, with no stale return.
- Misaligned low address bits [1:0] are ignored.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs perf_if_gnt, perf_d_gnt, perf_conflict (32 bits each, wrap-around).
  - They count fetch grants, data grants, and cycles with if_req & d_req respectively.
  - All are cleared by rst.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - owner_t enum (OWN_NONE, OWN_IF_RD, OWN_D_RD);
  - BE_FULL = 4'hF;
  - default STARVE_LIMIT.
- One natural sub-module, mem_arb_starve_ctr: the saturating starvation counter with a force_if output.
- Grant logic and owner register stay in the top module.

Test Plan:
- Reset: hold rst for 2 cycles with if_req = d_req = 1 -> if_gnt = d_gnt = mem_en = 0 and both rvalid = 0. On the first cycle after release, d_gnt = 1.
- Fetch alone:
  - if_addr = 0x0000_0010 and mem_rdata = 0xDEADBEEF next cycle.
  - -> mem_addr = 4 and mem_we = 0; if_rvalid = 1 one cycle later with if_rdata = 0xDEADBEEF; d_rvalid = 0.
- Store then load back-to-back on data port:
  - Store d_addr = 0x20, d_be = 4'b0011, d_wdata = 0x1234_5678.
  - -> mem_we = 1, mem_be = 4'b0011, mem_addr = 8, with no d_rvalid.
  - The next-cycle load gives d_rvalid one cycle after its grant.
- Starvation: hold if_req = d_req = 1 continuously with STARVE_LIMIT = 4.
  - -> grant sequence D,D,D,D,IF,D,D,D,D,IF; each IF grant is followed by if_rvalid.
- Interleaved reads: alternate the fetch grant and the data load grant each cycle.
  - -> each rvalid goes only to the port granted on the previous cycle, and no cycle has both rvalids.
- Mid-read reset: fetch granted in cycle N, rst = 1 in cycle N+1 -> if_rvalid = 0 at N+1 and N+2.
  - With MEM_ARB_PERF_EN defined: the perf counters read 0 after reset, and perf_conflict increments once per cycle with both requests high.
